// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//   Converts the MEM stage's single-cycle data-memory request into a two-phase
//   address/data bus handshake. The pipeline is stalled while an access is in
//   flight. The raw 32-bit read word is handed back for byte/half extraction.
//   The bridge also handles flushes from the exception unit and has a bus
//   watchdog that forces completion with an error pulse.
//
// Ports
//   cpu_clk_50M, cpu_rst         clock, synchronous active-high reset
//   mem_ce_i/we_i/sel_i          MEM-stage request (level, stable while stalled)
//   mem_addr_i/data_i            byte address and lane-aligned store data
//   flush_i                      pipeline flush (exception / eret)
//   stall_req_o                  stall request to the pipeline controller
//   rdata_o                      last completed load word
//   bus_err_o                    one-cycle pulse on watchdog expiry
//   bus_req_o/wr_o/be_o/addr_o/wdata_o   address-phase outputs (ADDR only)
//   bus_addr_ok_i, bus_data_ok_i, bus_rdata_i   bus handshake inputs
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic [31:0] rdata_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_wr;
    logic [3:0]        r_be;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_start;
    logic              w_busy;
    logic              w_expire;
    logic              w_timeout;
    logic              w_load_done;

    assign w_start  = mem_ce_i & ~flush_i;
    assign w_busy   = (r_state == S_ADDR) | (r_state == S_DATA) | (r_state == S_DRAIN);
    assign w_expire = w_busy & (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // A handshake arriving on the expiry cycle wins; only a genuinely stuck
    // phase is reported as a bus error.
    assign w_timeout = w_expire
                     & ~((r_state == S_ADDR) & bus_addr_ok_i)
                     & ~(((r_state == S_DATA) | (r_state == S_DRAIN)) & bus_data_ok_i);

    // Load data is only captured when the access really completes and the
    // pipeline has not been flushed underneath it.
    assign w_load_done = (r_state == S_DATA) & bus_data_ok_i & ~flush_i & ~r_wr;

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_ADDR;
            end
            S_ADDR: begin
                // addr_ok beats flush: once the bus has the address, the data
                // phase must be seen through (or drained).
                if (bus_addr_ok_i)  w_next = S_DATA;
                else if (w_timeout) w_next = S_DONE;
                else if (flush_i)   w_next = S_IDLE;
            end
            S_DATA: begin
                if (bus_data_ok_i)  w_next = flush_i ? S_IDLE : S_DONE;
                else if (w_timeout) w_next = S_DONE;
                else if (flush_i)   w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus_data_ok_i | w_timeout) w_next = S_IDLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        stall_req_o = 1'b0;
        bus_req_o   = 1'b0;
        bus_wr_o    = 1'b0;
        bus_be_o    = 4'b0000;
        bus_addr_o  = 32'h0;
        bus_wdata_o = 32'h0;
        unique case (r_state)
            S_IDLE:  stall_req_o = w_start;
            S_ADDR: begin
                stall_req_o = 1'b1;
                bus_req_o   = 1'b1;
                bus_wr_o    = r_wr;
                bus_be_o    = r_be;
                bus_addr_o  = r_addr;
                bus_wdata_o = r_wdata;
            end
            S_DATA:  stall_req_o = 1'b1;
            S_DRAIN: stall_req_o = 1'b1;
            S_DONE:  stall_req_o = 1'b0;
            default: stall_req_o = 1'b0;
        endcase
    end

    assign bus_err_o = w_timeout;
    assign rdata_o   = r_rdata;

    // ---------------------------------------------------------------- state regs
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_be    <= 4'b0000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && w_start) begin
                r_wr    <= mem_we_i;
                r_be    <= mem_sel_i;
                r_addr  <= {mem_addr_i[31:2], 2'b00};
                r_wdata <= mem_data_i;
            end

            // Watchdog restarts for each bus phase; DRAIN keeps counting from
            // the DATA phase so a dead bus cannot hold the pipeline forever.
            if (((r_state == S_IDLE) && (w_next == S_ADDR)) ||
                ((r_state == S_ADDR) && (w_next == S_DATA)))
                r_cnt <= '0;
            else if (w_busy)
                r_cnt <= r_cnt + 1'b1;

            if (w_load_done)
                r_rdata <= bus_rdata_i;
            else if (w_timeout && !r_wr && (r_state != S_DRAIN))
                r_rdata <= 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce, we, flush, aok, dok;
    logic [3:0]  sel;
    logic [31:0] addr, wdata, brdata;
    logic        stall, berr, breq, bwr;
    logic [3:0]  bbe;
    logic [31:0] rdata, baddr, bwdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.TIMEOUT_CYC(8), .CNT_W(9)) dut (
        .cpu_clk_50M  (clk),
        .cpu_rst      (rst),
        .mem_ce_i     (ce),
        .mem_we_i     (we),
        .mem_sel_i    (sel),
        .mem_addr_i   (addr),
        .mem_data_i   (wdata),
        .flush_i      (flush),
        .stall_req_o  (stall),
        .rdata_o      (rdata),
        .bus_err_o    (berr),
        .bus_req_o    (breq),
        .bus_wr_o     (bwr),
        .bus_be_o     (bbe),
        .bus_addr_o   (baddr),
        .bus_wdata_o  (bwdata),
        .bus_addr_ok_i(aok),
        .bus_data_ok_i(dok),
        .bus_rdata_i  (brdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        ce = 0; we = 0; sel = 0; addr = 0; wdata = 0;
        flush = 0; aok = 0; dok = 0; brdata = 0;
    endtask

    initial begin
        int stalls;
        int errs;
        idle_in();
        rst = 1;
        nxt(); nxt();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err",   berr,  0);
        chk("rst_req",   breq,  0);
        chk("rst_wr",    bwr,   0);
        chk("rst_be",    bbe,   0);
        chk("rst_addr",  baddr, 0);
        chk("rst_wdata", bwdata, 0);
        rst = 0;

        // ---- load, zero wait
        ce = 1; we = 0; addr = 32'h0000_1006; sel = 4'b1100; #1;
        chk("t1_c0_stall", stall, 1);
        chk("t1_c0_req",   breq,  0);
        nxt();
        aok = 1; #1;
        chk("t1_c1_req",   breq,  1);
        chk("t1_c1_addr",  baddr, 32'h0000_1004);
        chk("t1_c1_be",    bbe,   4'b1100);
        chk("t1_c1_wr",    bwr,   0);
        chk("t1_c1_stall", stall, 1);
        nxt();
        aok = 0; dok = 1; brdata = 32'hDEAD_BEEF; #1;
        chk("t1_c2_req",   breq,  0);
        chk("t1_c2_addr",  baddr, 0);
        chk("t1_c2_stall", stall, 1);
        nxt();
        dok = 0; brdata = 0; #1;
        chk("t1_c3_stall", stall, 0);
        chk("t1_c3_rdata", rdata, 32'hDEAD_BEEF);
        nxt();
        // ce was still high through DONE; no new access may have started
        ce = 0; #1;
        chk("t1_c4_req",   breq,  0);
        chk("t1_c4_stall", stall, 0);
        chk("t1_c4_rdata", rdata, 32'hDEAD_BEEF);
        nxt();

        // ---- store with waits: 3 ADDR cycles, 3 DATA cycles
        ce = 1; we = 1; sel = 4'b0010; addr = 32'h0000_2001; wdata = 32'h0000_AB00;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            aok = (i == 3);
            dok = (i == 6);
            brdata = (i == 6) ? 32'hFFFF_FFFF : 32'h0;
            #1;
            if (stall) stalls++;
            if (i >= 1 && i <= 3) begin
                chk("t2_wr",    bwr,    1);
                chk("t2_be",    bbe,    4'b0010);
                chk("t2_addr",  baddr,  32'h0000_2000);
                chk("t2_wdata", bwdata, 32'h0000_AB00);
            end
            nxt();
        end
        idle_in(); #1;
        chk("t2_stalls", stalls, 7);
        chk("t2_rdata",  rdata,  32'hDEAD_BEEF);
        nxt();

        // ---- flush before addr_ok
        ce = 1; we = 0; sel = 4'hF; addr = 32'h0000_3000; #1;
        chk("t3_c0_stall", stall, 1);
        nxt();
        #1; chk("t3_c1_req", breq, 1);
        nxt();
        flush = 1; #1; chk("t3_c2_req", breq, 1);
        nxt();
        idle_in(); #1;
        chk("t3_c3_req",   breq,  0);
        chk("t3_c3_stall", stall, 0);
        chk("t3_c3_rdata", rdata, 32'hDEAD_BEEF);
        nxt();
        #1; chk("t3_c4_req", breq, 0);

        // ---- addr_ok beats flush; flush with data_ok discards
        ce = 1; addr = 32'h0000_4000; sel = 4'hF; #1;
        nxt();
        aok = 1; flush = 1; #1;
        nxt();
        aok = 0; flush = 0; ce = 0; #1;
        chk("t4_data_stall", stall, 1);
        chk("t4_data_req",   breq,  0);
        dok = 1; flush = 1; brdata = 32'h55AA_55AA;
        nxt();
        idle_in(); #1;
        chk("t4_stall", stall, 0);
        chk("t4_rdata", rdata, 32'hDEAD_BEEF);
        nxt();
        #1; chk("t4_req", breq, 0);

        // ---- flush in DATA, data_ok 2 cycles later
        ce = 1; addr = 32'h0000_5000; sel = 4'hF; #1;
        nxt();
        aok = 1; #1;
        nxt();
        aok = 0; flush = 1; ce = 0; #1;
        chk("t5_flush_stall", stall, 1);
        nxt();
        flush = 0; #1;
        chk("t5_drain1_stall", stall, 1);
        chk("t5_drain1_req",   breq,  0);
        nxt();
        dok = 1; brdata = 32'h1234_5678; #1;
        chk("t5_drain2_stall", stall, 1);
        nxt();
        idle_in(); #1;
        chk("t5_stall", stall, 0);
        chk("t5_rdata", rdata, 32'hDEAD_BEEF);
        chk("t5_req",   breq,  0);
        nxt();

        // ---- watchdog: data_ok never comes
        ce = 1; we = 0; addr = 32'h0000_6000; sel = 4'hF; #1;
        nxt();
        aok = 1; #1;
        nxt();
        aok = 0;
        errs = 0;
        for (int j = 1; j <= 8; j++) begin
            #1;
            if (berr) errs++;
            if (j == 8) chk("t6_err_8th", berr, 1);
            chk("t6_stall", stall, 1);
            nxt();
        end
        #1;
        chk("t6_done_stall", stall, 0);
        chk("t6_done_rdata", rdata, 0);
        chk("t6_done_err",   berr,  0);
        chk("t6_err_count",  errs,  1);
        idle_in();
        nxt();

        // ---- reset mid-DATA, then a stray data_ok
        ce = 1; addr = 32'h0000_7000; sel = 4'hF; #1;
        nxt();
        aok = 1; nxt();
        aok = 0; dok = 1; brdata = 32'h0BAD_F00D; nxt();
        idle_in(); #1;
        chk("t7_pre_rdata", rdata, 32'h0BAD_F00D);
        nxt();
        ce = 1; addr = 32'h0000_7100; #1;
        nxt();
        aok = 1; nxt();
        aok = 0; rst = 1; nxt();
        rst = 0; ce = 0; dok = 1; brdata = 32'hAAAA_5555; #1;
        chk("t7_rst_stall", stall, 0);
        chk("t7_rst_rdata", rdata, 0);
        chk("t7_rst_req",   breq,  0);
        chk("t7_rst_err",   berr,  0);
        nxt();
        dok = 0; #1;
        chk("t7_post_rdata", rdata, 0);
        chk("t7_post_stall", stall, 0);
        chk("t7_post_req",   breq,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Data-memory bus bridge that sits directly downstream of the MEM stage. It takes the stage's combinational single-cycle request (chip enable, write enable, byte select, address, write data) and runs it as a two-phase address/data handshake on the data bus. It stalls the pipeline until the access completes and returns the raw read word to the MEM stage for byte/half extraction. It also handles flush from the exception unit and includes a bus watchdog.

## Interface
Parameters:
- TIMEOUT_CYC, 256: maximum cycles in ADDR or DATA before forced completion with error.
- CNT_W, 9: width of the watchdog counter; must hold TIMEOUT_CYC.

Ports (one clock; reset is synchronous and active-high):
- cpu_clk_50M  in  1  core clock; all state changes on its rising edge.
- cpu_rst  in  1  synchronous active-high reset.
- mem_ce_i  in  1  access request from the MEM stage (level; held stable while stalled).
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  4  byte enables.
- mem_addr_i  in  32  physical byte address, already stripped to the low 29 bits.
- mem_data_i  in  32  store data, already lane-aligned.
- flush_i  in  1  exception/eret flush of the pipeline.
- stall_req_o  out  1  stall request to the pipeline controller.
- rdata_o  out  32  read word returned to the MEM stage.
- bus_err_o  out  1  one-cycle pulse on watchdog expiry.
- bus_req_o  out  1  address-phase request.
- bus_wr_o  out  1  write flag for the address phase.
- bus_be_o  out  4  byte enables.
- bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata_o  out  32  write data.
- bus_addr_ok_i  in  1  address phase accepted this cycle.
- bus_data_ok_i  in  1  data phase complete this cycle; read data valid.
- bus_rdata_i  in  32  read data, sampled only when bus_data_ok_i=1.

## Operation
- States: IDLE, ADDR, DATA, DRAIN, DONE.
- Start condition: start = mem_ce_i & ~flush_i.
- IDLE:
  - On start: latch we, sel, aligned address and wdata into request registers; go to ADDR.
  - Ignore bus_data_ok_i and bus_addr_ok_i.
- ADDR:
  - bus_req_o=1; bus_wr_o, bus_be_o, bus_addr_o and bus_wdata_o are driven from the request registers only.
  - bus_addr_ok_i=1 → go to DATA. This takes priority over flush_i in the same cycle.
  - flush_i=1 with bus_addr_ok_i=0 → abandon the request and go to IDLE.
- DATA:
  - bus_req_o=0.
  - bus_data_ok_i=1 → on a load, rdata_o <= bus_rdata_i; go to DONE.
  - flush_i=1 with bus_data_ok_i=0 → go to DRAIN.
  - flush_i=1 with bus_data_ok_i=1 in the same cycle → go to IDLE and discard the data.
- DRAIN: wait for bus_data_ok_i, discard the data, then go to IDLE.
- DONE:
  - Stall is released for exactly one cycle so the pipeline advances.
  - No new request is started in this cycle, even if mem_ce_i=1; the next cycle is IDLE.
- Stores: rdata_o keeps its previous value.
- rdata_o holds its value until the next load completes.
- Watchdog:
  - The counter clears on entry to ADDR and on entry to DATA, and increments every cycle spent in ADDR, DATA or DRAIN.
  - On reaching TIMEOUT_CYC-1: pulse bus_err_o, set rdata_o=0 on a load, and go to DONE (to IDLE if in DRAIN).
- stall_req_o = (IDLE & start) | ADDR | DATA | DRAIN. It is combinational from state and inputs.
- Bus outputs are zero in all states except ADDR.

## Timing
- Reset values, all taken at the edge where cpu_rst=1:
  - State: IDLE.
  - Outputs: stall_req_o=0, rdata_o=0, bus_err_o=0, bus_req_o=0, bus_wr_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0.
  - Request registers and watchdog: 0.
- Reset mid-transaction: return to IDLE immediately; a later stray bus_data_ok_i is ignored.
- Best-case latency (addr_ok in the first ADDR cycle, data_ok in the first DATA cycle): cycle 0 IDLE (stall=1), cycle 1 ADDR, cycle 2 DATA, cycle 3 DONE (stall=0, rdata_o valid). That is 3 stall cycles in total.
- Each cycle of addr_ok or data_ok delay adds one stall cycle.
- Back-to-back accesses are separated by at least one IDLE cycle.

## Test plan
- Load, zero wait: mem_ce_i=1, we=0, addr=0x0000_1006, sel=4'b1100; addr_ok in cycle 1, data_ok in cycle 2 with rdata 0xDEAD_BEEF → bus_addr_o=0x0000_1004, stall high in cycles 0–2 and low in cycle 3, rdata_o=0xDEAD_BEEF from cycle 3.
- Store with waits: we=1, sel=4'b0010, wdata=0x0000_AB00; addr_ok after 2 cycles, data_ok after 3 more → bus_wr_o=1 and bus_be_o=4'b0010 for all 3 ADDR cycles, 7 stall cycles in total, rdata_o unchanged.
- Flush before addr_ok (flush in cycle 2 of ADDR) → bus_req_o=0 next cycle, state IDLE, stall low, no data latched.
- Flush in DATA: data_ok arrives 2 cycles after the flush with rdata 0x1234_5678 → stall stays high through DRAIN, rdata_o is not updated, then IDLE.
- Timeout: TIMEOUT_CYC=8, bus never asserts data_ok → bus_err_o pulses once on the 8th DATA cycle, rdata_o=0, then DONE with stall=0.
- Reset mid-DATA, then data_ok 1 cycle later → all outputs 0, state stays IDLE, rdata_o stays 0.
